// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the memory word and the RAM handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_link_reg.sv
// LL/SC reservation: one linked address plus a valid flag, with an address compare.
module mem_link_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  set,
    input  logic  clear,
    input  word_t set_addr,
    input  word_t cmp_addr,
    output logic  valid,
    output logic  addr_eq
);

    word_t addr_reg;
    logic  valid_reg;

    // A new LL reservation takes precedence over any clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
        end else if (set) begin
            valid_reg <= 1'b1;
            addr_reg  <= set_addr;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid   = valid_reg;
    assign addr_eq = (addr_reg == cmp_addr);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// data priority bounded by a starvation limit and LL/SC link tracking.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  logic      datomic,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT,
        SCFAIL
    } arb_state_t;

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    arb_state_t    state_reg, state_next;
    logic [SW-1:0] dstreak_reg, dstreak_next;

    logic dreq, is_sc, is_ll, is_rd, ram_done;
    logic icomplete, dcomplete, scfail_done;
    logic link_valid, link_eq, link_set, link_clear;

    assign dreq     = dREN | dWEN;
    assign is_sc    = dWEN & datomic;
    assign is_ll    = dREN & datomic & ~dWEN;
    assign is_rd    = dREN & ~dWEN;
    assign ram_done = (ramstate == ACCESS) || (ramstate == ERROR);

    // Completion qualifiers are masked during reset so nothing is reported.
    assign icomplete   = ~RST & (state_reg == IGNT) & iREN & ram_done;
    assign dcomplete   = ~RST & (state_reg == DGNT) & dreq & ram_done;
    assign scfail_done = ~RST & (state_reg == SCFAIL) & dreq;

    assign link_set   = dcomplete & is_ll;
    assign link_clear = (dcomplete & dWEN & link_eq) | (dcomplete & is_sc) | scfail_done;

    mem_link_reg u_link (
        .CLK      (CLK),
        .RST      (RST),
        .set      (link_set),
        .clear    (link_clear),
        .set_addr (daddr),
        .cmp_addr (daddr),
        .valid    (link_valid),
        .addr_eq  (link_eq)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            dstreak_reg <= '0;
        end else begin
            state_reg   <= state_next;
            dstreak_reg <= dstreak_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dstreak_next = dstreak_reg;
        unique case (state_reg)
            IDLE: begin
                if (dreq && !(iREN && dstreak_reg == LIMIT)) begin
                    state_next = (is_sc && !(link_valid && link_eq)) ? SCFAIL : DGNT;
                end else if (iREN) begin
                    state_next = IGNT;
                end
            end
            IGNT:    if (!iREN || ram_done) state_next = IDLE;
            DGNT:    if (!dreq || ram_done) state_next = IDLE;
            SCFAIL:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // The streak only counts data grants that overtook a waiting fetch.
        if (!iREN || (state_reg == IDLE && state_next == IGNT)) begin
            dstreak_next = '0;
        end else if (state_reg == IDLE && state_next == DGNT && dstreak_reg != LIMIT) begin
            dstreak_next = dstreak_reg + 1'b1;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (!RST) begin
            unique case (state_reg)
                IGNT: begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                end
                DGNT: begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = is_rd;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        iwait = iREN & ~icomplete;
        dwait = dreq & ~(dcomplete | scfail_done);
        iload = icomplete ? ramload : '0;
        dload = '0;
        if (dcomplete) begin
            if (is_sc)      dload = 32'd1;
            else if (is_rd) dload = ramload;
        end
        err = (icomplete | dcomplete) & (ramstate == ERROR);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions,
// a monitor pops and compares them whenever a requester's wait drops.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN, datomic;
    word_t     iaddr, daddr, dstore, rd_data;
    logic      iwait, dwait, ramREN, ramWEN, err;
    word_t     iload, dload, ramaddr, ramstore;
    ramstate_t ramstate, resp_state;
    int        busy_lat, busy_cnt;

    typedef struct {
        logic        is_i;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic mon_is_i;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .datomic  (datomic),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (rd_data),
        .ramstate (ramstate),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    // RAM responder: BUSY for busy_lat cycles of a request, then resp_state.
    always_comb begin
        if (ramREN || ramWEN) ramstate = (busy_cnt >= busy_lat) ? resp_state : BUSY;
        else                  ramstate = FREE;
    end

    always @(posedge CLK) begin
        if ((ramREN || ramWEN) && ramstate == BUSY) busy_cnt <= busy_cnt + 1;
        else                                        busy_cnt <= 0;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(logic is_i, logic ren, logic wen, logic [31:0] addr,
                                logic [31:0] store, logic [31:0] load, logic e);
        exp_t r;
        r.is_i = is_i; r.ren = ren; r.wen = wen; r.addr = addr;
        r.store = store; r.load = load; r.err = e;
        return r;
    endfunction

    always @(negedge CLK) begin
        if (!RST && ((iREN && !iwait) || ((dREN || dWEN) && !dwait))) begin
            mon_is_i = iREN && !iwait;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion actual=i%0b required=none", mon_is_i);
            end else begin
                mon_e = sb_q.pop_front();
                check("owner_is_i", {31'd0, mon_is_i}, {31'd0, mon_e.is_i});
                check("ramREN", {31'd0, ramREN}, {31'd0, mon_e.ren});
                check("ramWEN", {31'd0, ramWEN}, {31'd0, mon_e.wen});
                check("ramaddr", ramaddr, mon_e.addr);
                check("ramstore", ramstore, mon_e.store);
                check("load", mon_is_i ? iload : dload, mon_e.load);
                check("err", {31'd0, err}, {31'd0, mon_e.err});
            end
            done_cnt++;
            $display("txn %0d: owner=%s addr=%h ren=%0b wen=%0b load_i=%h load_d=%h err=%0b",
                     done_cnt, mon_is_i ? "I" : "D", ramaddr, ramREN, ramWEN, iload, dload, err);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(int k, int max_cyc);
        int target = done_cnt + k;
        int cyc = 0;
        while (done_cnt < target && cyc < max_cyc) begin
            @(posedge CLK);
            cyc++;
        end
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout actual=%0d required=%0d", done_cnt, target);
        end
    endtask

    task automatic idle_d();
        dREN = 0; dWEN = 0; datomic = 0; daddr = '0; dstore = '0;
    endtask

    task automatic data_txn(logic ren, logic wen, logic at, logic [31:0] a, logic [31:0] st, exp_t e);
        sb_q.push_back(e);
        dREN = ren; dWEN = wen; datomic = at; daddr = a; dstore = st;
        wait_done(1, 40);
        #1 idle_d();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1; iREN = 0; iaddr = '0; idle_d();
        rd_data = '0; busy_lat = 0; resp_state = ACCESS;
        repeat (2) @(posedge CLK);
        #1 iREN = 1; dREN = 1;
        @(negedge CLK);
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rst_iwait", {31'd0, iwait}, 32'd1);
        check("rst_dwait", {31'd0, dwait}, 32'd1);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        tick();
        RST = 0; iREN = 0; dREN = 0;
        @(negedge CLK);
        check("idle_iwait", {31'd0, iwait}, 32'd0);
        check("idle_dwait", {31'd0, dwait}, 32'd0);

        // Instruction fetch with two BUSY cycles.
        tick();
        busy_lat = 2; rd_data = 32'hDEADBEEF; iaddr = 32'h40; iREN = 1;
        sb_q.push_back(mk(1, 1, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0));
        @(negedge CLK);
        check("lat_n_ramREN", {31'd0, ramREN}, 32'd0);
        check("lat_n_iwait", {31'd0, iwait}, 32'd1);
        @(negedge CLK);
        check("lat_n1_ramREN", {31'd0, ramREN}, 32'd1);
        check("lat_n1_iwait_busy", {31'd0, iwait}, 32'd1);
        wait_done(1, 20);
        #1 iREN = 0; busy_lat = 0;
        tick();

        // Both requesters held: D,D,D,D,I twice.
        rd_data = 32'h1234; iaddr = 32'h44; daddr = 32'h80;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) sb_q.push_back(mk(0, 1, 0, 32'h80, 32'h0, 32'h1234, 0));
            sb_q.push_back(mk(1, 1, 0, 32'h44, 32'h0, 32'h1234, 0));
        end
        iREN = 1; dREN = 1;
        wait_done(10, 100);
        #1 iREN = 0; idle_d();
        tick();

        // LL then SC succeeds; a second SC fails.
        rd_data = 32'h77;
        data_txn(1, 0, 1, 32'h100, 32'h0, mk(0, 1, 0, 32'h100, 32'h0, 32'h77, 0));
        data_txn(0, 1, 1, 32'h100, 32'h5, mk(0, 0, 1, 32'h100, 32'h5, 32'h1, 0));
        data_txn(0, 1, 1, 32'h100, 32'h5, mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0));

        // LL, intervening SW to the same address, then SC fails.
        rd_data = 32'h88;
        data_txn(1, 0, 1, 32'h200, 32'h0, mk(0, 1, 0, 32'h200, 32'h0, 32'h88, 0));
        data_txn(0, 1, 0, 32'h200, 32'h9, mk(0, 0, 1, 32'h200, 32'h9, 32'h0, 0));
        data_txn(0, 1, 1, 32'h200, 32'h6, mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0));

        // Read completing with ERROR, request held into the following IDLE cycle.
        resp_state = ERROR; rd_data = 32'hCAFE0000;
        sb_q.push_back(mk(0, 1, 0, 32'h300, 32'h0, 32'hCAFE0000, 1));
        dREN = 1; daddr = 32'h300;
        wait_done(1, 40);
        #1 resp_state = ACCESS; rd_data = 32'h31;
        @(negedge CLK);
        check("err_after_ramREN", {31'd0, ramREN}, 32'd0);
        check("err_after_err", {31'd0, err}, 32'd0);
        check("err_after_dwait", {31'd0, dwait}, 32'd1);
        sb_q.push_back(mk(0, 1, 0, 32'h300, 32'h0, 32'h31, 0));
        wait_done(1, 40);
        #1 idle_d();
        tick();

        // Reset during a BUSY data write clears state and link.
        rd_data = 32'h44;
        data_txn(1, 0, 1, 32'h400, 32'h0, mk(0, 1, 0, 32'h400, 32'h0, 32'h44, 0));
        busy_lat = 10;
        dWEN = 1; daddr = 32'h500; dstore = 32'hAA;
        @(negedge CLK);
        @(negedge CLK);
        check("pre_rst_ramWEN", {31'd0, ramWEN}, 32'd1);
        check("pre_rst_dwait", {31'd0, dwait}, 32'd1);
        @(posedge CLK);
        #1 RST = 1;
        @(negedge CLK);
        check("in_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("in_rst_dwait", {31'd0, dwait}, 32'd1);
        @(posedge CLK);
        #1 RST = 0; busy_lat = 0;
        sb_q.push_back(mk(0, 0, 1, 32'h500, 32'hAA, 32'h0, 0));
        @(negedge CLK);
        check("post_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        wait_done(1, 40);
        #1 idle_d();
        tick();
        data_txn(0, 1, 1, 32'h400, 32'h3, mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0));

        repeat (3) tick();
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
